// File: rtl/status_pkg.sv
// Shared flag definitions for the status flag unit and its save/restore stack.
// Bit order of every flag vector is [3]=V [2]=Z [1]=S [0]=C.
package status_pkg;

  localparam int FLAG_W = 4;

  localparam int IDX_V = 3;
  localparam int IDX_Z = 2;
  localparam int IDX_S = 1;
  localparam int IDX_C = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  function automatic flags_t pack_flags(
    input logic v,
    input logic z,
    input logic s,
    input logic c
  );
    flags_t f;
    f        = '0;
    f[IDX_V] = v;
    f[IDX_Z] = z;
    f[IDX_S] = s;
    f[IDX_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/status_flag_unit_stack.sv
// LIFO of saved flag words with level tracking and misuse detection.
// Push+pop together swaps the top entry; at level 0 only the push happens.
module flag_stack
  import status_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          pop_ok,
  output logic          misuse
);

  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  flags_t        mem [2**LW];
  logic [LW-1:0] top_idx;
  logic          swap;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign top_idx = level - ONE;
  assign top     = mem[top_idx];

  assign pop_ok  = pop & ~empty;
  assign swap    = push & pop_ok;
  assign do_push = push & ~pop_ok & ~full;
  assign do_pop  = pop_ok & ~push;

  // A swap on a full stack is legal; only a lone push can overflow.
  assign misuse  = (push & ~pop & full)
                 | (pop & empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (do_push) begin
      level <= level + ONE;
    end else if (do_pop) begin
      level <= level - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (swap) begin
        mem[top_idx] <= din;
      end else if (do_push) begin
        mem[level] <= din;
      end
    end
  end

endmodule

// File: rtl/status_flag_unit.sv
// ALU status flag register with per-flag masking, software write,
// optional sticky overflow and a save/restore stack.
module status_flag_unit
  import status_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int STICKY_V = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update,
  input  logic [WIDTH-1:0]           word_out,
  input  logic                       cout,
  input  logic                       cmsb,
  input  logic [3:0]                 flag_we,
  input  logic                       sw_wr,
  input  logic [3:0]                 sw_data,
  input  logic                       push,
  input  logic                       pop,
  output logic                       V,
  output logic                       Z,
  output logic                       S,
  output logic                       C,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  flags_t flags_q;
  flags_t flags_d;
  flags_t calc;
  flags_t upd;
  flags_t stk_top;
  logic   pop_ok;
  logic   misuse;
  logic   err_q;
  logic   sel_pop;
  logic   sel_sw;
  logic   sel_upd;

  assign calc = pack_flags(
    cout ^ cmsb,
    (word_out == '0),
    word_out[WIDTH-1],
    cout
  );

  always_comb begin
    upd = flags_q;
    for (int i = 0; i < FLAG_W; i++) begin
      if (flag_we[i]) begin
        upd[i] = calc[i];
      end
    end
    // Sticky overflow only ever sets on update.
    if (STICKY_V != 0 && flag_we[IDX_V]) begin
      upd[IDX_V] = flags_q[IDX_V] | calc[IDX_V];
    end
  end

  assign sel_pop = pop_ok;
  assign sel_sw  = sw_wr & ~pop_ok;
  assign sel_upd = update & ~sw_wr & ~pop_ok;

  always_comb begin
    flags_d = flags_q;
    unique case (1'b1)
      sel_pop: flags_d = stk_top;
      sel_sw:  flags_d = sw_data;
      sel_upd: flags_d = upd;
      default: flags_d = flags_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_q | misuse;
    end
  end

  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (flags_q),
    .top    (stk_top),
    .level  (level),
    .full   (full),
    .empty  (empty),
    .pop_ok (pop_ok),
    .misuse (misuse)
  );

  assign V   = flags_q[IDX_V];
  assign Z   = flags_q[IDX_Z];
  assign S   = flags_q[IDX_S];
  assign C   = flags_q[IDX_C];
  assign err = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Scoreboard bench: directed steps queue expected state, a negedge
// monitor pops and compares. A second instance runs with sticky V.
module tb_status_flag_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic [7:0] word_out = '0;
  logic       cout = 1'b0;
  logic       cmsb = 1'b0;
  logic [3:0] flag_we = '0;
  logic       sw_wr = 1'b0;
  logic [3:0] sw_data = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;

  logic       V, Z, S, C, full, empty, err;
  logic [2:0] level;
  logic       V_s, Z_s, S_s, C_s, full_s, empty_s, err_s;
  logic [2:0] level_s;

  always #5 clk = ~clk;

  status_flag_unit #(.WIDTH(8), .DEPTH(4), .STICKY_V(0)) dut (
    .clk(clk), .rst(rst), .update(update), .word_out(word_out),
    .cout(cout), .cmsb(cmsb), .flag_we(flag_we), .sw_wr(sw_wr),
    .sw_data(sw_data), .push(push), .pop(pop),
    .V(V), .Z(Z), .S(S), .C(C), .level(level),
    .full(full), .empty(empty), .err(err)
  );

  status_flag_unit #(.WIDTH(8), .DEPTH(4), .STICKY_V(1)) dut_s (
    .clk(clk), .rst(rst), .update(update), .word_out(word_out),
    .cout(cout), .cmsb(cmsb), .flag_we(flag_we), .sw_wr(sw_wr),
    .sw_data(sw_data), .push(push), .pop(pop),
    .V(V_s), .Z(Z_s), .S(S_s), .C(C_s), .level(level_s),
    .full(full_s), .empty(empty_s), .err(err_s)
  );

  typedef struct {
    string    name;
    logic [3:0] f;
    int       lvl;
    logic     e;
    bit       chk_s;
    logic     vs;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step(
    input string      nm,
    input logic       a_rst,
    input logic       a_upd,
    input logic [3:0] a_we,
    input logic [7:0] a_w,
    input logic       a_co,
    input logic       a_cm,
    input logic       a_sw,
    input logic [3:0] a_swd,
    input logic       a_pu,
    input logic       a_po,
    input logic [3:0] x_f,
    input int         x_lvl,
    input logic       x_err,
    input bit         x_chk,
    input logic       x_vs
  );
    exp_t e;
    @(negedge clk);
    #1;
    rst      = a_rst;
    update   = a_upd;
    flag_we  = a_we;
    word_out = a_w;
    cout     = a_co;
    cmsb     = a_cm;
    sw_wr    = a_sw;
    sw_data  = a_swd;
    push     = a_pu;
    pop      = a_po;
    @(posedge clk);
    e.name  = nm;
    e.f     = x_f;
    e.lvl   = x_lvl;
    e.e     = x_err;
    e.chk_s = x_chk;
    e.vs    = x_vs;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if ({V, Z, S, C} !== e.f || level !== 3'(e.lvl)
          || full !== (e.lvl == 4) || empty !== (e.lvl == 0)
          || err !== e.e) begin
        n_fail++;
        $display("FAIL %s: got VZSC=%b level=%0d full=%b empty=%b err=%b, want VZSC=%b level=%0d err=%b",
                 e.name, {V, Z, S, C}, level, full, empty, err,
                 e.f, e.lvl, e.e);
      end
      if (e.chk_s) begin
        n_tests++;
        if (V_s !== e.vs) begin
          n_fail++;
          $display("FAIL %s_sticky: got V=%b, want V=%b",
                   e.name, V_s, e.vs);
        end
      end
    end
  end

  initial begin
    //   name         rst upd we     word   co cm sw swd   pu po  VZSC   lvl err chk vs
    step("rst0",      1, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 1, 0);
    step("rst1",      1, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 1, 0);
    step("upd_all",   0, 1, 4'hF, 8'h00, 1, 0, 0, 4'h0, 0, 0, 4'b1101, 0, 0, 1, 1);
    step("sw_f",      0, 0, 4'h0, 8'h00, 0, 0, 1, 4'hF, 0, 0, 4'b1111, 0, 0, 1, 1);
    step("upd_c",     0, 1, 4'h1, 8'h80, 0, 0, 0, 4'h0, 0, 0, 4'b1110, 0, 0, 1, 1);
    step("sticky",    0, 1, 4'hF, 8'h01, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 1, 1);
    step("sw_clr",    0, 1, 4'hF, 8'h00, 1, 0, 1, 4'h0, 0, 0, 4'b0000, 0, 0, 1, 0);
    step("upd_z",     0, 1, 4'hF, 8'h00, 1, 1, 0, 4'h0, 0, 0, 4'b0101, 0, 0, 1, 0);
    step("hold",      0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 4'b0101, 0, 0, 0, 0);
    step("push_upd",  0, 1, 4'hF, 8'h80, 0, 1, 0, 4'h0, 1, 0, 4'b1010, 1, 0, 0, 0);
    step("push_sw1",  0, 0, 4'h0, 8'h00, 0, 0, 1, 4'h3, 1, 0, 4'b0011, 2, 0, 0, 0);
    step("push_sw2",  0, 0, 4'h0, 8'h00, 0, 0, 1, 4'hC, 1, 0, 4'b1100, 3, 0, 0, 0);
    step("push_sw3",  0, 0, 4'h0, 8'h00, 0, 0, 1, 4'h6, 1, 0, 4'b0110, 4, 0, 0, 0);
    step("push_full", 0, 0, 4'h0, 8'h00, 0, 0, 1, 4'h9, 1, 0, 4'b1001, 4, 1, 0, 0);
    step("pop_sw",    0, 0, 4'h0, 8'h00, 0, 0, 1, 4'hF, 0, 1, 4'b1100, 3, 1, 0, 0);
    step("pop3",      0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 4'b0011, 2, 1, 0, 0);
    step("swap2",     0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 1, 1, 4'b1010, 2, 1, 0, 0);
    step("pop2",      0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 4'b0011, 1, 1, 0, 0);
    step("pop1",      0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 4'b0101, 0, 1, 0, 0);
    step("pop_empty", 0, 1, 4'hF, 8'h00, 0, 0, 0, 4'h0, 0, 1, 4'b0100, 0, 1, 0, 0);
    step("rst_a",     1, 1, 4'hF, 8'hFF, 1, 0, 1, 4'hF, 1, 0, 4'b0000, 0, 0, 1, 0);
    step("swap0",     0, 0, 4'h0, 8'h00, 0, 0, 1, 4'h6, 1, 1, 4'b0110, 1, 1, 0, 0);
    step("pop0",      0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 4'b0000, 0, 1, 0, 0);
    step("rst_b",     1, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step("fill1",     0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 1, 0, 4'b0000, 1, 0, 0, 0);
    step("fill2",     0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 1, 0, 4'b0000, 2, 0, 0, 0);
    step("fill3",     0, 1, 4'hF, 8'hFF, 1, 1, 0, 4'h0, 1, 0, 4'b0011, 3, 0, 0, 0);
    step("rst_upd",   1, 1, 4'hF, 8'h00, 1, 0, 0, 4'h0, 1, 0, 4'b0000, 0, 0, 1, 0);
    step("pop_rst",   0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 4'b0000, 0, 1, 0, 0);
    step("idle",      0, 0, 4'h0, 8'h00, 0, 0, 0, 4'h0, 0, 0, 4'b0000, 0, 1, 0, 0);

    repeat (4) @(negedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
